// File: rtl/frame_proc_scheduler_pkg.sv
// Shared state encoding, RAM-port owner codes and watchdog defaults.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAPTURE  = 3'd1,
    S_PROC_RUN = 3'd2,
    S_PROC_ACK = 3'd3,
    S_FAULT    = 3'd4
  } sched_state_t;

  localparam logic [1:0] SEL_CAM  = 2'd0;
  localparam logic [1:0] SEL_PROC = 2'd1;
  localparam logic [1:0] SEL_DISP = 2'd2;

  localparam int unsigned       WD_W            = 24;
  localparam logic [WD_W-1:0]   TIMEOUT_CYC_DEF = 24'd200000;

  // RAM port owner implied by a state; FAULT and unused codes park on display.
  function automatic logic [1:0] owner_of(input sched_state_t s);
    case (s)
      S_CAPTURE:              return SEL_CAM;
      S_PROC_RUN, S_PROC_ACK: return SEL_PROC;
      default:                return SEL_DISP;
    endcase
  endfunction

endpackage

// File: rtl/frame_proc_scheduler_watchdog.sv
// Clear/enable cycle counter; o_expire is high while enabled on the last allowed count.
module sched_watchdog
  import frame_sched_pkg::*;
#(
  parameter int unsigned  W     = WD_W,
  parameter logic [W-1:0] LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [W-1:0] LAST = LIMIT - W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/frame_proc_scheduler.sv
// Frame buffer port sequencer: capture -> process -> display with watchdog.
module frame_proc_scheduler
  import frame_sched_pkg::*;
#(
  parameter logic [WD_W-1:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned     DISP_FRAMES = 4,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             cap_frame_done,
  input  logic             proc_done,
  input  logic             vsync,
  output logic             cap_en,
  output logic             proc_active,
  output logic             disp_en,
  output logic [1:0]       mux_sel,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] frame_count,
  output logic [2:0]       state_dbg
);

  localparam logic [3:0] VS_LAST = 4'(DISP_FRAMES);

  sched_state_t     r_state;
  sched_state_t     w_state_nx;
  logic [1:0]       r_mux_sel;
  logic [1:0]       w_sel_nx;
  logic             r_cap_en;
  logic             r_proc_active;
  logic             r_disp_en;
  logic             r_busy;
  logic             r_error;
  logic             r_done_armed;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [3:0]       r_vs_cnt;
  logic             w_wd_run;
  logic             w_wd_expire;
  logic             w_done_ok;
  logic             w_vs_ready;

  assign w_wd_run   = (r_state == S_PROC_RUN);
  // done only counts once it has been seen low in this pass, so a level left
  // high from a previous pass cannot complete the new one
  assign w_done_ok  = r_proc_active && r_done_armed && proc_done;
  assign w_vs_ready = cont && (r_vs_cnt == VS_LAST);
  assign w_sel_nx   = owner_of(w_state_nx);

  sched_watchdog #(
    .W     (WD_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_wd_run),
    .i_en     (w_wd_run),
    .o_expire (w_wd_expire)
  );

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:     if (start || w_vs_ready) w_state_nx = S_CAPTURE;
      S_CAPTURE:  if (r_cap_en && cap_frame_done) w_state_nx = S_PROC_RUN;
      S_PROC_RUN: begin
        if (w_done_ok)        w_state_nx = S_PROC_ACK;
        else if (w_wd_expire) w_state_nx = S_FAULT;
      end
      S_PROC_ACK: if (!proc_done) w_state_nx = S_IDLE;
      default:    w_state_nx = start ? S_CAPTURE : S_FAULT;
    endcase
  end

  // an enable rises only once mux_sel has already pointed at its owner for a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mux_sel     <= SEL_DISP;
      r_cap_en      <= 1'b0;
      r_proc_active <= 1'b0;
      r_disp_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
      r_done_armed  <= 1'b0;
      r_frame_cnt   <= '0;
      r_vs_cnt      <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_mux_sel     <= w_sel_nx;
      r_cap_en      <= (w_state_nx == S_CAPTURE)  && (r_mux_sel == SEL_CAM);
      r_proc_active <= (w_state_nx == S_PROC_RUN) && (r_mux_sel == SEL_PROC);
      r_disp_en     <= (w_state_nx == S_IDLE)     && (r_mux_sel == SEL_DISP);
      r_busy        <= (w_state_nx == S_CAPTURE) || (w_state_nx == S_PROC_RUN) ||
                       (w_state_nx == S_PROC_ACK);
      r_error       <= (w_state_nx == S_FAULT);
      r_done_armed  <= (r_state == S_PROC_RUN) && (r_done_armed || !proc_done);
      if ((r_state == S_PROC_RUN) && (w_state_nx == S_PROC_ACK)) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      if (r_state != S_IDLE) begin
        r_vs_cnt <= '0;
      end else if (vsync && (r_vs_cnt != VS_LAST)) begin
        r_vs_cnt <= r_vs_cnt + 4'd1;
      end
    end
  end

  assign cap_en      = r_cap_en;
  assign proc_active = r_proc_active;
  assign disp_en     = r_disp_en;
  assign mux_sel     = r_mux_sel;
  assign busy        = r_busy;
  assign error       = r_error;
  assign frame_count = r_frame_cnt;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_frame_proc_scheduler.sv
// Bench for frame_proc_scheduler: vector table, directed corners, random run vs model.
module tb_frame_proc_scheduler;

  localparam int TO = 100;
  localparam int DF = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          cfd = 1'b0;
  logic          pd = 1'b0;
  logic          vsync = 1'b0;
  logic          cap_en;
  logic          proc_active;
  logic          disp_en;
  logic [1:0]    mux_sel;
  logic          busy;
  logic          error;
  logic [CW-1:0] frame_count;
  logic [2:0]    state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  frame_proc_scheduler #(
    .TIMEOUT_CYC (24'd100),
    .DISP_FRAMES (DF),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cont           (cont),
    .cap_frame_done (cfd),
    .proc_done      (pd),
    .vsync          (vsync),
    .cap_en         (cap_en),
    .proc_active    (proc_active),
    .disp_en        (disp_en),
    .mux_sel        (mux_sel),
    .busy           (busy),
    .error          (error),
    .frame_count    (frame_count),
    .state_dbg      (state_dbg)
  );

  // Reference model: phase of the frame cycle, who owns the port and for how long.
  typedef struct {
    int phase;     // 0 idle, 1 capture, 2 processing, 3 ack, 4 fault
    int owner;     // 0 camera, 1 processor, 2 display
    int age;       // cycles the current owner has held the port (saturates at 1)
    int frames;
    int vs;
    int wd;        // cycles already spent processing
    bit seen_low;  // done observed low during this processing pass
  } model_t;

  model_t m;

  function automatic int owner_of_phase(input int ph);
    case (ph)
      1:       return 0;
      2, 3:    return 1;
      default: return 2;
    endcase
  endfunction

  function automatic model_t step(input model_t c, input logic r, input logic st,
                                  input logic co, input logic cf, input logic p,
                                  input logic vs);
    model_t n = c;
    if (r) begin
      n.phase = 0; n.owner = 2; n.age = 0; n.frames = 0;
      n.vs = 0; n.wd = 0; n.seen_low = 1'b0;
      return n;
    end
    case (c.phase)
      0: if (st || (co && c.vs >= DF)) n.phase = 1;
      1: if (c.age >= 1 && cf) n.phase = 2;
      2: begin
        if (c.age >= 1 && c.seen_low && p) begin
          n.phase = 3;
          n.frames = (c.frames + 1) % (1 << CW);
        end else if (c.wd == TO - 1) begin
          n.phase = 4;
        end
      end
      3: if (!p) n.phase = 0;
      default: if (st) n.phase = 1;
    endcase
    n.vs = (c.phase == 0) ? ((vs && c.vs < DF) ? c.vs + 1 : c.vs) : 0;
    n.wd = (c.phase == 2) ? c.wd + 1 : 0;
    n.seen_low = (c.phase == 2) && (c.seen_low || !p);
    if (owner_of_phase(n.phase) == c.owner) begin
      n.age = 1;
    end else begin
      n.owner = owner_of_phase(n.phase);
      n.age = 0;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("mdl_state", 32'(state_dbg),   32'(m.phase));
    chk("mdl_mux",   32'(mux_sel),     32'(m.owner));
    chk("mdl_cap",   32'(cap_en),      32'(m.phase == 1 && m.age >= 1));
    chk("mdl_proc",  32'(proc_active), 32'(m.phase == 2 && m.age >= 1));
    chk("mdl_disp",  32'(disp_en),     32'(m.phase == 0 && m.age >= 1));
    chk("mdl_busy",  32'(busy),        32'(m.phase >= 1 && m.phase <= 3));
    chk("mdl_err",   32'(error),       32'(m.phase == 4));
    chk("mdl_fc",    32'(frame_count), 32'(m.frames));
  endtask

  // one clock: model sees the same inputs as the DUT, outputs checked on the falling edge
  task automatic tick();
    @(posedge clk);
    m = step(m, rst, start, cont, cfd, pd, vsync);
    @(negedge clk);
    check_model();
  endtask

  function automatic logic sel_out(input int w);
    case (w)
      0:       return cap_en;
      1:       return proc_active;
      2:       return disp_en;
      default: return error;
    endcase
  endfunction

  task automatic wait_out(input int w, input int lim, input string nm);
    int k = 0;
    while (sel_out(w) !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    chk(nm, 32'(sel_out(w)), 32'(1));
  endtask

  task automatic do_pass(input bit use_start, input bit clr_cont);
    if (use_start) begin
      start = 1'b1; tick(); start = 1'b0;
    end
    wait_out(0, 20, "pass_cap_en");
    if (clr_cont) cont = 1'b0;
    cfd = 1'b1; tick(); cfd = 1'b0;
    wait_out(1, 5, "pass_proc_active");
    pd = 1'b1; tick();
    chk("pass_ack", 32'(state_dbg), 32'(3));
    tick();
    pd = 1'b0; tick();
    chk("pass_idle", 32'(state_dbg), 32'(0));
  endtask

  typedef struct {
    int rst, st, co, cf, pd, vs;
    int s, mux, cap, pa, de, bz, er, fc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n2;
    //           rst st co cf pd vs   s mux cap pa de bz er fc
    tbl[0]  = '{ 1, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0, 0, 0 };
    tbl[1]  = '{ 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 1, 0, 0, 0 };
    tbl[2]  = '{ 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0 };
    tbl[3]  = '{ 0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0, 1, 0, 0 };
    tbl[4]  = '{ 0, 0, 0, 1, 0, 0,   2, 1, 0, 0, 0, 1, 0, 0 };
    tbl[5]  = '{ 0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 1, 0, 0 };
    tbl[6]  = '{ 0, 0, 0, 0, 1, 0,   3, 1, 0, 0, 0, 1, 0, 1 };
    tbl[7]  = '{ 0, 0, 0, 0, 1, 0,   3, 1, 0, 0, 0, 1, 0, 1 };
    tbl[8]  = '{ 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0, 0, 1 };
    tbl[9]  = '{ 0, 0, 0, 0, 0, 1,   0, 2, 0, 0, 1, 0, 0, 1 };
    tbl[10] = '{ 0, 1, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 0, 1 };
    tbl[11] = '{ 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 0, 1, 0, 1 };
    tbl[12] = '{ 1, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0, 0, 0 };

    for (int i = 0; i < 13; i++) begin
      rst = (tbl[i].rst != 0); start = (tbl[i].st != 0); cont = (tbl[i].co != 0);
      cfd = (tbl[i].cf != 0);  pd = (tbl[i].pd != 0);    vsync = (tbl[i].vs != 0);
      tick();
      chk("tbl_state", 32'(state_dbg),   32'(tbl[i].s));
      chk("tbl_mux",   32'(mux_sel),     32'(tbl[i].mux));
      chk("tbl_cap",   32'(cap_en),      32'(tbl[i].cap));
      chk("tbl_proc",  32'(proc_active), 32'(tbl[i].pa));
      chk("tbl_disp",  32'(disp_en),     32'(tbl[i].de));
      chk("tbl_busy",  32'(busy),        32'(tbl[i].bz));
      chk("tbl_err",   32'(error),       32'(tbl[i].er));
      chk("tbl_fc",    32'(frame_count), 32'(tbl[i].fc));
    end
    rst = 1'b0; start = 1'b0; cont = 1'b0; cfd = 1'b0; pd = 1'b0; vsync = 1'b0;

    // idle hold
    repeat (50) tick();
    chk("idle_busy",  32'(busy),      32'(0));
    chk("idle_state", 32'(state_dbg), 32'(0));
    chk("idle_disp",  32'(disp_en),   32'(1));

    // watchdog expiry after exactly TO processing cycles
    start = 1'b1; tick(); start = 1'b0;
    wait_out(0, 10, "wd_cap_en");
    cfd = 1'b1; tick(); cfd = 1'b0;
    n2 = 0;
    while (state_dbg === 3'd2 && n2 < 300) begin
      n2++;
      tick();
    end
    chk("wd_cycles", 32'(n2),          32'(TO));
    chk("wd_state",  32'(state_dbg),   32'(4));
    chk("wd_error",  32'(error),       32'(1));
    chk("wd_mux",    32'(mux_sel),     32'(2));
    chk("wd_enables", 32'({cap_en, proc_active, disp_en}), 32'(0));
    cont = 1'b1;
    repeat (6) begin vsync = 1'b1; tick(); vsync = 1'b0; tick(); end
    chk("fault_ignores_cont", 32'(state_dbg), 32'(4));
    cont = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("fault_exit_state", 32'(state_dbg), 32'(1));
    chk("fault_exit_error", 32'(error),     32'(0));

    // done arriving in the final watchdog cycle wins
    wait_out(0, 10, "sim_cap_en");
    cfd = 1'b1; tick(); cfd = 1'b0;
    repeat (TO - 1) tick();
    chk("sim_still_run", 32'(state_dbg), 32'(2));
    pd = 1'b1; tick();
    chk("sim_state", 32'(state_dbg), 32'(3));
    chk("sim_error", 32'(error),     32'(0));
    pd = 1'b0; tick();
    chk("sim_idle", 32'(state_dbg), 32'(0));

    // continuous mode
    rst = 1'b1; tick(); rst = 1'b0;
    cont = 1'b1;
    do_pass(1'b1, 1'b0);
    repeat (3) begin vsync = 1'b1; tick(); vsync = 1'b0; tick(); end
    repeat (10) tick();
    chk("cont_3vs_idle", 32'(state_dbg), 32'(0));
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    chk("cont_auto_capture", 32'(state_dbg), 32'(1));
    do_pass(1'b0, 1'b0);
    repeat (4) begin vsync = 1'b1; tick(); vsync = 1'b0; tick(); end
    do_pass(1'b0, 1'b1);
    repeat (6) begin vsync = 1'b1; tick(); vsync = 1'b0; tick(); end
    repeat (10) tick();
    chk("cont_off_idle", 32'(state_dbg),   32'(0));
    chk("cont_fc3",      32'(frame_count), 32'(3));

    // stale done and stray pulses while processing
    start = 1'b1; tick(); start = 1'b0;
    wait_out(0, 10, "rob_cap_en");
    pd = 1'b1; cfd = 1'b1; tick(); cfd = 1'b0;
    repeat (5) tick();
    chk("stale_done_hold", 32'(state_dbg), 32'(2));
    start = 1'b1; cfd = 1'b1; tick(); start = 1'b0; cfd = 1'b0;
    chk("stray_state", 32'(state_dbg), 32'(2));
    chk("stray_mux",   32'(mux_sel),   32'(1));
    pd = 1'b0; tick(); pd = 1'b1; tick();
    chk("fresh_done", 32'(state_dbg), 32'(3));
    pd = 1'b0; tick();

    // reset mid-processing
    start = 1'b1; tick(); start = 1'b0;
    wait_out(0, 10, "rst_cap_en");
    cfd = 1'b1; tick(); cfd = 1'b0;
    tick();
    chk("rst_pre_active", 32'(proc_active), 32'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_proc",  32'(proc_active), 32'(0));
    chk("rst_state", 32'(state_dbg),   32'(0));
    chk("rst_fc",    32'(frame_count), 32'(0));

    // randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(599) == 0);
      start = ($urandom_range(11) == 0);
      cfd   = ($urandom_range(5) == 0);
      vsync = ($urandom_range(4) == 0);
      if ($urandom_range(59) == 0)  pd = ~pd;
      if ($urandom_range(149) == 0) cont = ~cont;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_proc_scheduler.md
Name: frame_proc_scheduler

Overview:
Top-level sequencer for the single-port frame buffer.
- Grants the RAM port in turn to camera capture, the white-balance processor (active/done handshake) and the display scanout.
- Runs one capture -> process -> display cycle per start pulse, or repeats continuously.
- Guards against processor hangs with a watchdog, and exposes status and a frame counter.

Parameters:
TIMEOUT_CYC, 24'd200000, processor watchdog limit in clk cycles (one full-frame pass is ~153.6k cycles)
DISP_FRAMES, 4, vsync pulses shown in IDLE before auto-restart when cont=1 (1..15)
CNT_W, 16, frame_count width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request to begin a frame cycle
cont  in  1  level; 1 = repeat frame cycles automatically
cap_frame_done  in  1  single-cycle pulse: camera finished writing a frame
proc_done  in  1  processor done level
vsync  in  1  single-cycle pulse per displayed frame
cap_en  out  1  camera may write the buffer
proc_active  out  1  processor run request
disp_en  out  1  display may read the buffer
mux_sel  out  2  RAM port owner: 0 camera, 1 processor, 2 display
busy  out  1  high in any state except IDLE and FAULT
error  out  1  watchdog expired
frame_count  out  CNT_W  completed processing passes
state_dbg  out  3  current state encoding

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE, mux_sel=2, disp_en=0 (asserted on the 2nd cycle after reset via the guard rule)
  - cap_en=0, proc_active=0, busy=0, error=0, frame_count=0, watchdog=0, vsync count=0
- Ownership guard:
  - On any owner change, the old owner's enable drops in the same cycle mux_sel changes.
  - The new owner's enable asserts exactly one cycle later.
  - No two enables are ever high together.
- States (3-bit encoding):
  - IDLE=0. Owner is display. Go to CAPTURE on start. If cont=1, also go to CAPTURE after DISP_FRAMES vsync pulses have been counted in IDLE. The vsync count clears on entry to IDLE.
  - CAPTURE=1. Owner is camera. Go to PROC_RUN on cap_frame_done.
  - PROC_RUN=2. Owner is processor; proc_active=1 from the guard cycle on. The watchdog increments each cycle.
    - Go to PROC_ACK when proc_done=1.
    - Go to FAULT when watchdog == TIMEOUT_CYC-1 and proc_done=0.
    - If both happen in the same cycle, proc_done wins.
  - PROC_ACK=3. proc_active=0, and mux_sel is held at 1 so the final write completes. frame_count increments on entry, wrapping at 2^CNT_W. Go to IDLE when proc_done=0.
  - FAULT=4. All enables are 0, mux_sel=2, error=1, cont is ignored. start clears error and goes to CAPTURE.
- Entering PROC_RUN clears the watchdog.
- Ignored inputs:
  - start outside IDLE/FAULT.
  - cap_frame_done outside CAPTURE, and during the CAPTURE guard cycle.
  - proc_done outside PROC_RUN/PROC_ACK, and during the PROC_RUN guard cycle. A stale done held high must not complete a pass.
- rst mid-operation forces the reset values immediately. Enables drop in the same cycle.
- cont going low mid-cycle finishes the current pass, then stays in IDLE.
- Unused encodings 5-7 are treated as FAULT.

Decomposition:
- Package frame_sched_pkg holds:
  - state constants S_IDLE..S_FAULT
  - SEL_CAM=2'd0, SEL_PROC=2'd1, SEL_DISP=2'd2
  - the default TIMEOUT_CYC
- One sub-module, sched_watchdog: a clear/enable counter with parameterised limit, producing an expire pulse.

Test Plan:
- Reset then idle: after rst, mux_sel=2 and disp_en=1 on the 2nd cycle; start=0 for 50 cycles -> busy=0, no state change.
- Single pass, cont=0:
  - start -> mux_sel=0, then cap_en=1 one cycle later.
  - cap_frame_done -> cap_en=0 with mux_sel=1, then proc_active=1 next cycle.
  - proc_done high 1 cycle later -> proc_active=0.
  - proc_done low -> IDLE, frame_count=1.
- Watchdog, TIMEOUT_CYC=100: proc_done never asserted -> FAULT on cycle 100 of PROC_RUN, error=1, all enables 0; then start -> error=0, state CAPTURE.
- Simultaneous expiry: proc_done asserted in the cycle watchdog==99 -> PROC_ACK, error stays 0.
- Continuous mode, cont=1, DISP_FRAMES=4:
  - After pass 1, 4 vsync pulses -> auto CAPTURE.
  - 3 pulses only -> remains in IDLE.
  - After 3 passes, frame_count=3.
- Robustness:
  - start and cap_frame_done pulsed during PROC_RUN -> ignored.
  - rst asserted in PROC_RUN -> next cycle proc_active=0, state_dbg=0, frame_count=0.
